lc3_mem_responder: RTL and testbench

Memory-side responder for the LC-3 datapath's memory interface. Services the CPU's MAR/MDR read and write requests from a word-addressed RAM array. Decodes the LC-3 memory-mapped device page into keyboard (KBSR/KBDR) and display (DSR/DDR) registers, each with a valid/ready byte stream toward the testbench or top level. Sits beside the datapath and controller, on the far end of the memory-write and MDR-load strobes.

---
 rtl/lc3_mem_responder_if.sv | 38 +++
 rtl/lc3_mem_responder.sv | 152 +++++++++++++++
 tb/tb_lc3_mem_responder.sv | 382 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lc3_mem_responder_if.sv
// Bus bundle between the LC-3 datapath (master) and the memory responder
// (slave): MAR/MDR access, keyboard byte stream in, display byte stream out.
interface lc3_mem_responder_if;
    // CPU memory access
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        memWE;
    logic        rd;
    logic [15:0] rdata;
    // Keyboard stream toward the responder
    logic        kb_valid;
    logic [7:0]  kb_data;
    logic        kb_ready;
    // Display stream away from the responder
    logic        disp_valid;
    logic [7:0]  disp_data;
    logic        disp_ready;

    // Responder side
    modport slave (
        input  addr, wdata, memWE, rd,
        output rdata,
        input  kb_valid, kb_data,
        output kb_ready,
        output disp_valid, disp_data,
        input  disp_ready
    );

    // Datapath / environment side
    modport master (
        output addr, wdata, memWE, rd,
        input  rdata,
        output kb_valid, kb_data,
        input  kb_ready,
        input  disp_valid, disp_data,
        output disp_ready
    );
endinterface : lc3_mem_responder_if

// File: rtl/lc3_mem_responder.sv
// LC-3 memory-side responder: word-addressed RAM below xFE00 plus the
// memory-mapped keyboard (KBSR/KBDR) and display (DSR/DDR) registers.
// Reads are combinational from addr; writes and read side effects land on
// the rising clock edge.
module lc3_mem_responder #(
    parameter int MEM_WORDS  = 4096,
    parameter int DISP_DELAY = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    lc3_mem_responder_if.slave   bus
);

    localparam int AW = $clog2(MEM_WORDS);
    // Counter only ever holds DISP_DELAY-1 down to 0.
    localparam int CW = (DISP_DELAY > 1) ? $clog2(DISP_DELAY) : 1;

    localparam logic [15:0] IO_BASE   = 16'hFE00;
    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;

    typedef enum logic [1:0] {
        D_IDLE,
        D_SEND,
        D_BUSY
    } disp_state_e;

    // Storage and state
    logic [15:0]  mem [MEM_WORDS];
    logic         kb_full;
    logic [7:0]   kb_byte;
    disp_state_e  disp_state;
    logic [7:0]   disp_byte;
    logic [CW-1:0] busy_cnt;
    logic         overrun;

    // Address decode
    logic          is_ram;
    logic [AW-1:0] ram_idx;
    logic          rd_kbdr;
    logic          rd_dsr;
    logic          wr_ddr;
    logic          disp_idle;

    assign is_ram    = (bus.addr < IO_BASE);
    assign ram_idx   = bus.addr[AW-1:0];
    assign rd_kbdr   = bus.rd && (bus.addr == KBDR_ADDR);
    assign rd_dsr    = bus.rd && (bus.addr == DSR_ADDR);
    assign wr_ddr    = bus.memWE && (bus.addr == DDR_ADDR);
    assign disp_idle = (disp_state == D_IDLE);

    // RAM write port; addresses in the device page never reach the array.
    // NOTE: the RAM array has no reset branch -- resetting a memory turns it
    // into thousands of flops and defeats RAM inference.
    always_ff @(posedge clk) begin
        if (bus.memWE && is_ram) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            mem[ram_idx] <= bus.wdata;
        end
    end

    // Keyboard holding register: accept a byte when empty, empty on KBDR read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kb_full <= 1'b0;
            kb_byte <= 8'h00;
        end else if (kb_full) begin
            // Only a read of a full register has a side effect; reading an
            // empty KBDR just returns the stale byte.
            if (rd_kbdr) begin
                kb_full <= 1'b0;
            end
        end else if (bus.kb_valid) begin
            kb_byte <= bus.kb_data;
            kb_full <= 1'b1;
        end
    end

    // Display FSM: latch a DDR write, offer it until taken, then stay busy
    // for DISP_DELAY cycles before accepting the next character.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp_state <= D_IDLE;
            disp_byte  <= 8'h00;
            busy_cnt   <= '0;
            overrun    <= 1'b0;
        end else begin
            // A dropped character outranks a coincident DSR read so the
            // loss is never silently cleared.
            if (wr_ddr && !disp_idle) begin
                overrun <= 1'b1;
            end else if (rd_dsr) begin
                overrun <= 1'b0;
            end

            case (disp_state)
                D_IDLE: begin
                    if (wr_ddr) begin
                        disp_byte  <= bus.wdata[7:0];
                        disp_state <= D_SEND;
                    end
                end
                D_SEND: begin
                    if (bus.disp_ready) begin
                        if (DISP_DELAY == 0) begin
                            disp_state <= D_IDLE;
                        end else begin
                            busy_cnt   <= CW'(DISP_DELAY - 1);
                            disp_state <= D_BUSY;
                        end
                    end
                end
                D_BUSY: begin
                    if (busy_cnt == '0) begin
                        disp_state <= D_IDLE;
                    end else begin
                        busy_cnt <= busy_cnt - 1'b1;
                    end
                end
                default: begin
                    disp_state <= D_IDLE;
                end
            endcase
        end
    end

    // Stream outputs are straight decodes of registered state.
    assign bus.kb_ready   = ~kb_full;
    assign bus.disp_valid = (disp_state == D_SEND);
    assign bus.disp_data  = disp_byte;

    // Combinational read mux: RAM below the device page, registers within it.
    always_comb begin
        // NOTE: default first so every path assigns rdata and no latch forms.
        bus.rdata = 16'h0000;
        if (is_ram) begin
            bus.rdata = mem[ram_idx];
        end else begin
            case (bus.addr)
                KBSR_ADDR: bus.rdata = {kb_full, 15'h0000};
                KBDR_ADDR: bus.rdata = {8'h00, kb_byte};
                DSR_ADDR:  bus.rdata = {disp_idle, 14'h0000, overrun};
                DDR_ADDR:  bus.rdata = {8'h00, disp_byte};
                default:   bus.rdata = 16'h0000;
            endcase
        end
    end

endmodule : lc3_mem_responder

// File: tb/tb_lc3_mem_responder.sv
// Directed bench for lc3_mem_responder: RAM access and wrap, keyboard
// handshake, display FSM timing, overrun, unmapped page, async reset.
module tb_lc3_mem_responder;

    localparam int MEM_WORDS  = 4096;
    localparam int DISP_DELAY = 4;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    lc3_mem_responder_if bus ();

    lc3_mem_responder #(
        .MEM_WORDS (MEM_WORDS),
        .DISP_DELAY(DISP_DELAY)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.addr       = 16'h0000;
        bus.wdata      = 16'h0000;
        bus.memWE      = 1'b0;
        bus.rd         = 1'b0;
        bus.kb_valid   = 1'b0;
        bus.kb_data    = 8'h00;
        bus.disp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_bus();
        #12;
        tests_run++;
        if (bus.kb_ready !== 1'b1) begin
            $display("FAIL reset_kb_ready got %b exp 1", bus.kb_ready);
            tests_failed++;
        end
        tests_run++;
        if (bus.disp_valid !== 1'b0 || bus.disp_data !== 8'h00) begin
            $display("FAIL reset_disp got valid=%b data=%h exp 0/00", bus.disp_valid, bus.disp_data);
            tests_failed++;
        end
        bus.addr = 16'hFE00;
        #1;
        tests_run++;
        if (bus.rdata !== 16'h0000) begin
            $display("FAIL reset_kbsr got %h exp 0000", bus.rdata);
            tests_failed++;
        end
        bus.addr = 16'hFE04;
        #1;
        tests_run++;
        if (bus.rdata !== 16'h8000) begin
            $display("FAIL reset_dsr got %h exp 8000", bus.rdata);
            tests_failed++;
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_ram();
        bus.addr  = 16'h3000;
        bus.wdata = 16'h1234;
        bus.memWE = 1'b1;
        tick();
        bus.memWE = 1'b0;
        bus.rd    = 1'b1;
        #1;
        tests_run++;
        if (bus.rdata !== 16'h1234) begin
            $display("FAIL ram_readback got %h exp 1234", bus.rdata);
            tests_failed++;
        end
        bus.rd = 1'b0;
        // x3000 + MEM_WORDS aliases onto x3000.
        bus.addr  = 16'h4000;
        bus.wdata = 16'hBEEF;
        bus.memWE = 1'b1;
        tick();
        bus.memWE = 1'b0;
        bus.addr  = 16'h3000;
        #1;
        tests_run++;
        if (bus.rdata !== 16'hBEEF) begin
            $display("FAIL ram_wrap got %h exp beef", bus.rdata);
            tests_failed++;
        end
        // Same-cycle write and read: old value visible until the edge.
        bus.wdata = 16'h5555;
        bus.memWE = 1'b1;
        bus.rd    = 1'b1;
        #1;
        tests_run++;
        if (bus.rdata !== 16'hBEEF) begin
            $display("FAIL ram_same_cycle_old got %h exp beef", bus.rdata);
            tests_failed++;
        end
        tick();
        bus.memWE = 1'b0;
        bus.rd    = 1'b0;
        #1;
        tests_run++;
        if (bus.rdata !== 16'h5555) begin
            $display("FAIL ram_same_cycle_new got %h exp 5555", bus.rdata);
            tests_failed++;
        end
    endtask

    task automatic test_keyboard();
        bus.kb_valid = 1'b1;
        bus.kb_data  = 8'h41;
        tick();
        bus.kb_data = 8'h42;
        bus.addr    = 16'hFE00;
        #1;
        tests_run++;
        if (bus.kb_ready !== 1'b0 || bus.rdata !== 16'h8000) begin
            $display("FAIL kb_accept got ready=%b kbsr=%h exp 0/8000", bus.kb_ready, bus.rdata);
            tests_failed++;
        end
        // Second byte held while full must not replace the first.
        tick();
        tick();
        bus.kb_valid = 1'b0;
        bus.addr     = 16'hFE02;
        bus.rd       = 1'b1;
        #1;
        tests_run++;
        if (bus.rdata !== 16'h0041) begin
            $display("FAIL kb_kbdr got %h exp 0041", bus.rdata);
            tests_failed++;
        end
        tick();
        bus.rd   = 1'b0;
        bus.addr = 16'hFE00;
        #1;
        tests_run++;
        if (bus.rdata !== 16'h0000 || bus.kb_ready !== 1'b1) begin
            $display("FAIL kb_cleared got kbsr=%h ready=%b exp 0000/1", bus.rdata, bus.kb_ready);
            tests_failed++;
        end
        // Reading KBDR while empty: stale byte, no state change.
        bus.addr = 16'hFE02;
        bus.rd   = 1'b1;
        tick();
        bus.rd = 1'b0;
        #1;
        tests_run++;
        if (bus.rdata !== 16'h0041 || bus.kb_ready !== 1'b1) begin
            $display("FAIL kb_stale got kbdr=%h ready=%b exp 0041/1", bus.rdata, bus.kb_ready);
            tests_failed++;
        end
    endtask

    task automatic test_display();
        bus.disp_ready = 1'b0;
        bus.addr       = 16'hFE06;
        bus.wdata      = 16'h0048;
        bus.memWE      = 1'b1;
        tick();
        bus.memWE = 1'b0;
        bus.addr  = 16'hFE04;
        for (int i = 0; i < 5; i++) begin
            #1;
            tests_run++;
            if (bus.disp_valid !== 1'b1 || bus.disp_data !== 8'h48 || bus.rdata !== 16'h0000) begin
                $display("FAIL disp_hold[%0d] got valid=%b data=%h dsr=%h exp 1/48/0000",
                         i, bus.disp_valid, bus.disp_data, bus.rdata);
                tests_failed++;
            end
            tick();
        end
        bus.disp_ready = 1'b1;
        tick();
        tests_run++;
        if (bus.disp_valid !== 1'b0) begin
            $display("FAIL disp_handshake got valid=%b exp 0", bus.disp_valid);
            tests_failed++;
        end
        tick();
        tick();
        tick();
        tests_run++;
        if (bus.rdata !== 16'h0000) begin
            $display("FAIL disp_busy_4 got dsr=%h exp 0000", bus.rdata);
            tests_failed++;
        end
        tick();
        tests_run++;
        if (bus.rdata !== 16'h8000) begin
            $display("FAIL disp_idle_5 got dsr=%h exp 8000", bus.rdata);
            tests_failed++;
        end
        bus.disp_ready = 1'b0;
        bus.addr       = 16'hFE06;
        #1;
        tests_run++;
        if (bus.rdata !== 16'h0048) begin
            $display("FAIL disp_ddr_read got %h exp 0048", bus.rdata);
            tests_failed++;
        end
    endtask

    task automatic test_overrun();
        bit done;
        bus.disp_ready = 1'b0;
        bus.addr       = 16'hFE06;
        bus.wdata      = 16'h0048;
        bus.memWE      = 1'b1;
        tick();
        bus.wdata = 16'h0049;
        tick();
        bus.memWE = 1'b0;
        bus.addr  = 16'hFE04;
        #1;
        tests_run++;
        if (bus.disp_data !== 8'h48 || bus.rdata !== 16'h0001) begin
            $display("FAIL ovr_set got data=%h dsr=%h exp 48/0001", bus.disp_data, bus.rdata);
            tests_failed++;
        end
        bus.rd = 1'b1;
        tick();
        bus.rd = 1'b0;
        #1;
        tests_run++;
        if (bus.rdata !== 16'h0000) begin
            $display("FAIL ovr_clear got dsr=%h exp 0000", bus.rdata);
            tests_failed++;
        end
        bus.disp_ready = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            if (bus.rdata[15] === 1'b1) done = 1'b1;
        end
        tests_run++;
        if (!done) begin
            $display("FAIL ovr_drain_timeout got dsr=%h exp bit15 set", bus.rdata);
            tests_failed++;
        end
        bus.disp_ready = 1'b0;
    endtask

    task automatic test_unmapped();
        bus.memWE = 1'b1;
        bus.addr  = 16'h0E08;
        bus.wdata = 16'hAAAA;
        tick();
        bus.addr  = 16'h0FFF;
        bus.wdata = 16'hBBBB;
        tick();
        bus.addr  = 16'hFE08;
        bus.wdata = 16'h1234;
        tick();
        bus.addr  = 16'hFFFF;
        bus.wdata = 16'h5678;
        tick();
        bus.addr  = 16'hFE00;
        bus.wdata = 16'hFFFF;
        tick();
        bus.memWE = 1'b0;
        #1;
        tests_run++;
        if (bus.rdata !== 16'h0000) begin
            $display("FAIL unm_kbsr_write got %h exp 0000", bus.rdata);
            tests_failed++;
        end
        bus.addr = 16'hFE08;
        #1;
        tests_run++;
        if (bus.rdata !== 16'h0000) begin
            $display("FAIL unm_fe08 got %h exp 0000", bus.rdata);
            tests_failed++;
        end
        bus.addr = 16'hFFFF;
        #1;
        tests_run++;
        if (bus.rdata !== 16'h0000) begin
            $display("FAIL unm_ffff got %h exp 0000", bus.rdata);
            tests_failed++;
        end
        bus.addr = 16'h0E08;
        #1;
        tests_run++;
        if (bus.rdata !== 16'hAAAA) begin
            $display("FAIL unm_ram_e08 got %h exp aaaa", bus.rdata);
            tests_failed++;
        end
        bus.addr = 16'h0FFF;
        #1;
        tests_run++;
        if (bus.rdata !== 16'hBBBB) begin
            $display("FAIL unm_ram_fff got %h exp bbbb", bus.rdata);
            tests_failed++;
        end
    endtask

    task automatic test_async_reset();
        bus.disp_ready = 1'b0;
        bus.addr       = 16'hFE06;
        bus.wdata      = 16'h0055;
        bus.memWE      = 1'b1;
        bus.kb_valid   = 1'b1;
        bus.kb_data    = 8'h66;
        tick();
        bus.memWE    = 1'b0;
        bus.kb_valid = 1'b0;
        #1;
        tests_run++;
        if (bus.disp_valid !== 1'b1 || bus.kb_ready !== 1'b0) begin
            $display("FAIL arst_pre got valid=%b ready=%b exp 1/0", bus.disp_valid, bus.kb_ready);
            tests_failed++;
        end
        #1;
        rst = 1'b0;
        #1;
        tests_run++;
        if (bus.disp_valid !== 1'b0 || bus.kb_ready !== 1'b1) begin
            $display("FAIL arst_async got valid=%b ready=%b exp 0/1", bus.disp_valid, bus.kb_ready);
            tests_failed++;
        end
        #3;
        rst = 1'b1;
        tick();
        bus.addr = 16'hFE04;
        #1;
        tests_run++;
        if (bus.rdata !== 16'h8000) begin
            $display("FAIL arst_dsr got %h exp 8000", bus.rdata);
            tests_failed++;
        end
        bus.addr = 16'hFE02;
        #1;
        tests_run++;
        if (bus.rdata !== 16'h0000) begin
            $display("FAIL arst_kbdr got %h exp 0000", bus.rdata);
            tests_failed++;
        end
        bus.addr = 16'hFE06;
        #1;
        tests_run++;
        if (bus.rdata !== 16'h0000) begin
            $display("FAIL arst_ddr got %h exp 0000", bus.rdata);
            tests_failed++;
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_ram();
        test_keyboard();
        test_display();
        test_overrun();
        test_unmapped();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_lc3_mem_responder
